// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op_e     : operation encodings carried on the 2-bit `op` input
//   - state_e  : sequencer states
//   - ITER_DEF : default iteration count (equals the 32-bit operand width)
//   - CNT_W    : width of the iteration counter
//   - helpers  : op classification and conditional absolute value
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int ITER_DEF = 32;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    // Magnitude of a two's-complement word when sgn is set; raw value otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// -----------------------------------------------------------------------------
// muldiv_addsub
// 33-bit adder/subtractor shared by the multiply and divide iterations.
// Ports:
//   x    in  33  first operand
//   y    in  33  second operand
//   sub  in  1   0: x + y, 1: x - y
//   sum  out 33  result (modulo 2^33)
//   cout out 1   carry out; when subtracting, 1 means x >= y (no borrow)
// -----------------------------------------------------------------------------
module muldiv_addsub (
    input  logic [32:0] x,
    input  logic [32:0] y,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    logic [32:0] y_eff;

    // Subtraction as x + ~y + 1 so one carry chain serves both directions.
    assign y_eff       = sub ? ~y : y;
    assign {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {33'd0, sub};

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with the architectural HI/LO
// registers. Fixed 34-cycle latency: one accept cycle, 32 RUN iterations,
// one FIX cycle for sign correction and commit.
// Ports:
//   clk    in  1   clock, rising edge
//   rst    in  1   synchronous active-high reset
//   start  in  1   request operation (sampled in IDLE only)
//   op     in  2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in  32  multiplicand / dividend
//   b      in  32  multiplier / divisor
//   flush  in  1   abort operation in flight (RUN or FIX)
//   hi_we  in  1   MTHI write enable (IDLE only)
//   lo_we  in  1   MTLO write enable (IDLE only)
//   wdata  in  32  MTHI/MTLO data
//   busy   out 1   operation accepted but not yet committed
//   done   out 1   one-cycle pulse, HI/LO updated this cycle
//   dz     out 1   divide by zero, valid with done
//   hi     out 32  HI register
//   lo     out 32  LO register
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    // Working registers. For multiply {acc, mplr} is the 64-bit product
    // shift register and mcand the multiplicand; for divide acc holds the
    // partial remainder, mplr the dividend/quotient and mcand the divisor.
    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    op_e               op_q,       op_d;
    logic [31:0]       acc_q,      acc_d;
    logic [31:0]       mplr_q,     mplr_d;
    logic [31:0]       mcand_q,    mcand_d;
    logic              neg_quo_q,  neg_quo_d;
    logic              neg_rem_q,  neg_rem_d;
    logic              dz_pend_q,  dz_pend_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              dz_q,       dz_d;
    logic [31:0]       hi_q,       hi_d;
    logic [31:0]       lo_q,       lo_d;

    // Shared adder/subtractor.
    logic [32:0] as_x, as_y, as_sum;
    logic        as_sub, as_cout;

    muldiv_addsub u_addsub (
        .x    (as_x),
        .y    (as_y),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    // Adder operand steering: divide subtracts the divisor from the
    // left-shifted remainder, multiply adds the multiplicand to acc.
    always_comb begin
        as_y = {1'b0, mcand_q};
        if (is_div(op_q)) begin
            as_x   = {acc_q, mplr_q[31]};
            as_sub = 1'b1;
        end else begin
            as_x   = {1'b0, acc_q};
            as_sub = 1'b0;
        end
    end

    // Intermediate values for the iteration and the final fix-up.
    logic        start_signed;
    logic [32:0] mul_step;
    logic [63:0] product;
    logic [63:0] product_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        start_signed = is_signed_op(op_e'(op));
        mul_step     = mplr_q[0] ? as_sum : {1'b0, acc_q};
        product      = {acc_q, mplr_q};
        product_fix  = neg_quo_q ? (~product + 64'd1) : product;
        quo_fix      = neg_quo_q ? (~mplr_q + 32'd1) : mplr_q;
        rem_fix      = neg_rem_q ? (~acc_q + 32'd1) : acc_q;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every _d starts as its _q (or a pulse default) so no path
        // through the case below can leave a variable unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        mcand_d   = mcand_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_pend_d = dz_pend_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                // MTHI/MTLO in the same cycle as start still land; the
                // commit at FIX overwrites them later.
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    op_d      = op_e'(op);
                    acc_d     = '0;
                    neg_quo_d = start_signed && (a[31] ^ b[31]);
                    neg_rem_d = start_signed && a[31];
                    dz_pend_d = is_div(op_e'(op)) && (b == 32'd0);
                    dz_d      = 1'b0;
                    if (is_div(op_e'(op))) begin
                        mplr_d  = abs32(a, start_signed);
                        mcand_d = abs32(b, start_signed);
                    end else begin
                        mplr_d  = abs32(b, start_signed);
                        mcand_d = abs32(a, start_signed);
                    end
                end
            end

            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div(op_q)) begin
                        // Restoring step: keep the trial difference only when
                        // it did not borrow. If the shifted remainder reached
                        // bit 32 it always exceeds the divisor, so dropping
                        // that bit on the restore path loses nothing.
                        if (as_cout) begin
                            acc_d  = as_sum[31:0];
                            mplr_d = {mplr_q[30:0], 1'b1};
                        end else begin
                            acc_d  = as_x[31:0];
                            mplr_d = {mplr_q[30:0], 1'b0};
                        end
                    end else begin
                        // Shift {carry, acc, mplr} right by one.
                        acc_d  = mul_step[32:1];
                        mplr_d = {mul_step[0], mplr_q[31:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = FIX;
                end
            end

            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    dz_d   = dz_pend_q;
                    if (is_div(op_q)) begin
                        // With a zero divisor every trial succeeds, so the
                        // remainder ends as |a| and its sign fix-up restores
                        // the original a; only LO needs forcing.
                        hi_d = rem_fix;
                        lo_d = dz_pend_q ? 32'hFFFF_FFFF : quo_fix;
                    end else begin
                        hi_d = product_fix[63:32];
                        lo_d = product_fix[31:0];
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of every other flop, independent of statement order.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            acc_q     <= '0;
            mplr_q    <= '0;
            mcand_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            mcand_q   <= mcand_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_pend_q <= dz_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
